// File: rtl/binary_mul_9_1_uni.sv
// binary_mul_9_1_uni
//   Fully pipelined unsigned WIDTH x WIDTH -> 2*WIDTH multiplier, radix-2:
//   one partial-product row (one bit of B) is accumulated per stage.
//   Latency is WIDTH+1 enabled edges (input register + WIDTH accumulate
//   stages); a new operand pair is accepted on every enabled edge.
//
//   Optional macro: VALID_OUT_EN adds p_valid, a valid bit travelling with
//   the data that is 1 when P holds a product captured after reset release.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous reset, active HIGH (name kept for compatibility)
//   en      in   pipeline advance enable; 0 freezes every register
//   A       in   WIDTH-bit unsigned multiplicand
//   B       in   WIDTH-bit unsigned multiplier
//   p_valid out  (VALID_OUT_EN only) product-valid flag aligned with P
//   P       out  2*WIDTH-bit registered unsigned product
module binary_mul_9_1_uni #(
    parameter int unsigned WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
`ifdef VALID_OUT_EN
    output logic                 p_valid,
`endif
    output logic [2*WIDTH-1:0]   P
);

    localparam int unsigned PW = 2 * WIDTH;

    // Operands travel alongside their partial sum: a_q[k]/b_q[k] belong to
    // stage k, s_q[k] is the sum after k rows. Stage 0 has an implicit sum of 0.
    logic [WIDTH-1:0] a_q [0:WIDTH-1];
    logic [WIDTH-1:0] b_q [0:WIDTH-1];
    logic [PW-1:0]    s_q [1:WIDTH];
    logic [PW-1:0]    row [1:WIDTH];

    // Partial-product row k: A shifted by k-1, gated by bit k-1 of B.
    always_comb begin
        for (int unsigned k = 1; k <= WIDTH; k++) begin
            row[k] = '0;
            if (b_q[k-1][k-1])
                row[k] = {{WIDTH{1'b0}}, a_q[k-1]} << (k - 1);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned k = 0; k < WIDTH; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int unsigned k = 1; k <= WIDTH; k++)
                s_q[k] <= '0;
        end else if (en) begin
            a_q[0] <= A;
            b_q[0] <= B;
            for (int unsigned k = 1; k < WIDTH; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
            s_q[1] <= row[1];
            for (int unsigned k = 2; k <= WIDTH; k++)
                s_q[k] <= s_q[k-1] + row[k];
        end
    end

    assign P = s_q[WIDTH];

`ifdef VALID_OUT_EN
    // v_q[0] marks stage 0; v_q[WIDTH] is aligned with P.
    logic [WIDTH:0] v_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            v_q <= '0;
        else if (en)
            v_q <= {v_q[WIDTH-1:0], 1'b1};
    end

    assign p_valid = v_q[WIDTH];
`endif

endmodule

// File: tb/tb_binary_mul_9_1_uni.sv
module tb_binary_mul_9_1_uni;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [8:0]  A   = '0;
    logic [8:0]  B   = '0;
    logic [17:0] P;
`ifdef VALID_OUT_EN
    logic        p_valid;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference: products of operands sampled on enabled edges since reset,
    // oldest first; P shows the oldest once ten have accumulated.
    logic [17:0] q [$];

    binary_mul_9_1_uni #(.WIDTH(9)) dut (
        .clk     (clk),
        .rst_n   (rst),
        .en      (en),
        .A       (A),
        .B       (B),
`ifdef VALID_OUT_EN
        .p_valid (p_valid),
`endif
        .P       (P)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] model_p();
        return (q.size() == 10) ? q[0] : 18'd0;
    endfunction

    // One clock edge: update model from what the DUT sampled, then compare.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst && en) begin
            q.push_back(18'(int'(A) * int'(B)));
            if (q.size() > 10) void'(q.pop_front());
        end
        #1;
        check(tag, P, model_p());
`ifdef VALID_OUT_EN
        check({tag, "_valid"}, {17'd0, p_valid}, {17'd0, q.size() == 10});
`endif
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        q.delete();
        #1 check("reset_async", P, 18'd0);
        for (int i = 0; i < 2; i++) tick("reset_hold");
        rst = 1'b0;
    endtask

    initial begin
        logic [8:0] ca [4];
        logic [8:0] cb [4];

        // Reset with busy inputs: P must stay 0 on every edge and mid-cycle.
        A = 9'd5; B = 9'd7; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("reset");
            #3 check("reset_midcycle", P, 18'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Single product, held operands.
        A = 9'd13; B = 9'd11;
        for (int i = 1; i <= 9; i++) tick("single");
        check("single_edge9", P, 18'd0);
        tick("single");
        check("single_edge10", P, 18'd143);

        // Extremes, each held ten edges.
        ca = '{9'd0, 9'd511, 9'd511, 9'd256};
        cb = '{9'd511, 9'd1, 9'd511, 9'd256};
        for (int c = 0; c < 4; c++) begin
            do_reset();
            A = ca[c]; B = cb[c];
            for (int i = 0; i < 10; i++) tick("extreme");
            check("extreme_abs", P, 18'(int'(ca[c]) * int'(cb[c])));
        end

        // Streaming, back-to-back operands.
        do_reset();
        ca = '{9'd1, 9'd2, 9'd100, 9'd511};
        cb = '{9'd1, 9'd3, 9'd200, 9'd510};
        for (int c = 0; c < 4; c++) begin
            A = ca[c]; B = cb[c];
            tick("stream_in");
        end
        A = '0; B = '0;
        for (int i = 5; i <= 9; i++) tick("stream_wait");
        tick("stream"); check("stream_e10", P, 18'd1);
        tick("stream"); check("stream_e11", P, 18'd6);
        tick("stream"); check("stream_e12", P, 18'd20000);
        tick("stream"); check("stream_e13", P, 18'd260610);

        // Stall: four enabled edges, five frozen, then resume.
        do_reset();
        A = 9'd9; B = 9'd9;
        for (int i = 0; i < 4; i++) tick("stall_pre");
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            A = 9'($urandom); B = 9'($urandom);
            tick("stall_frozen");
        end
        en = 1'b1; A = 9'd9; B = 9'd9;
        for (int i = 0; i < 6; i++) tick("stall_post");
        check("stall_result", P, 18'd81);

        // Randomized stream with occasional stalls and a mid-flight reset.
        for (int i = 0; i < 3000; i++) begin
            A  = 9'($urandom);
            B  = 9'($urandom);
            en = ($urandom_range(0, 7) != 0);
            if (i == 1500) begin
                do_reset();
                en = 1'b1;
            end
            tick("random");
        end

        // Drain with en held high so the tail products are all observed.
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            A = 9'($urandom); B = 9'($urandom);
            tick("drain");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
